uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an input FIFO and a valid/ready write interface. Frame format is set by parameters: data width, parity mode and stop-bit count. Queued frames are sent back-to-back with no idle gap. It sits between on-chip producers (command/response logic) and the board TX pin, and pairs with the UART receiver.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_fifo_if.sv | 13 +
 rtl/uart_sync_fifo.sv | 79 +++++++
 rtl/uart_tx_fifo.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

   localparam int CLK_HZ = 50_000_000;

   typedef enum logic [1:0] {
      PAR_NONE,
      PAR_ODD,
      PAR_EVEN
   } parity_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // Clock cycles per bit for a given baud rate, rounded to nearest.
   function automatic int div_ratio(input int baud);
      return (CLK_HZ + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side valid/ready write channel into the UART transmitter.
interface uart_tx_fifo_if #(
   parameter int DATA_BITS = 8
) ();

   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a registered head-of-queue output.
// rd_data always holds the oldest entry one cycle after it becomes the head,
// so the consumer can pop and use rd_data on the same edge.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level,
   output logic [LW-1:0]    level_next
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW-1:0]    rd_ptr_next;
   logic [LW-1:0]    level_reg;
   logic             full_reg;
   logic [WIDTH-1:0] rd_data_reg;
   logic             push_ok;
   logic             pop_ok;

   // Writes while full are dropped entirely; pops on empty are ignored.
   assign push_ok     = push && !full_reg;
   assign pop_ok      = pop && (level_reg != '0);
   assign rd_ptr_next = pop_ok ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

   // Occupancy after this edge; push and pop together leave it unchanged.
   always_comb begin
      level_next = level_reg;
      if (push_ok && !pop_ok) begin
         level_next = level_reg + 1'b1;
      end else if (pop_ok && !push_ok) begin
         level_next = level_reg - 1'b1;
      end
   end

   // Pointers, level and full flag; full reads 1 during reset so nothing is accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         full_reg   <= 1'b1;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         rd_ptr_reg <= rd_ptr_next;
         level_reg  <= level_next;
         full_reg   <= (level_next == LW'(DEPTH));
      end
   end

   // Storage array and registered head read, bypassing a write into the new head slot.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= wr_data;
      end
      rd_data_reg <= (push_ok && (wr_ptr_reg == rd_ptr_next)) ? wr_data : mem[rd_ptr_next];
   end

   assign rd_data = rd_data_reg;
   assign full    = full_reg;
   assign empty   = (level_reg == '0);
   assign level   = level_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; queued frames are sent back-to-back.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int DIV_RATIO  = div_ratio(115_200),
   parameter int FIFO_DEPTH = 8,
   localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   uart_tx_fifo_if.slave bus,
   output logic          tx_line,
   output logic          busy,
   output logic [LW-1:0] fifo_level
);

   localparam int DW = $clog2(DIV_RATIO);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_fifo: DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if (DIV_RATIO < 2) begin : g_bad_div_ratio
      $error("uart_tx_fifo: DIV_RATIO must be at least 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
   end

   tx_state_t            state_reg;
   logic [DW-1:0]        div_reg;
   logic [3:0]           bit_cnt_reg;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 par_reg;
   logic                 tx_line_reg;
   logic                 busy_reg;

   logic                 fifo_full;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_rd_data;
   logic [LW-1:0]        fifo_level_next;
   logic                 div_last;
   logic                 stop_done;
   logic                 pop;
   logic                 going_idle;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (bus.tx_valid),
      .wr_data    (bus.tx_data),
      .pop        (pop),
      .rd_data    (fifo_rd_data),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .level      (fifo_level),
      .level_next (fifo_level_next)
   );

   assign div_last  = (div_reg == DW'(DIV_RATIO - 1));
   assign stop_done = (state_reg == STOP) && div_last && (bit_cnt_reg == 4'(STOP_BITS - 1));
   // A word is taken from idle, or on the final stop edge so the next start follows directly.
   assign pop        = !fifo_empty && ((state_reg == IDLE) || stop_done);
   assign going_idle = !pop && ((state_reg == IDLE) || stop_done);

   // Frame sequencer: divider, bit counter, shifter, parity and registered line/busy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         div_reg     <= '0;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
         par_reg     <= 1'b0;
         tx_line_reg <= 1'b1;
         busy_reg    <= 1'b0;
      end else begin
         busy_reg <= !going_idle || (fifo_level_next != '0);
         case (state_reg)
            IDLE: begin
               if (pop) begin
                  shift_reg   <= fifo_rd_data;
                  div_reg     <= '0;
                  bit_cnt_reg <= '0;
                  par_reg     <= 1'b0;
                  tx_line_reg <= 1'b0;
                  state_reg   <= START;
               end
            end
            START: begin
               if (div_last) begin
                  div_reg     <= '0;
                  tx_line_reg <= shift_reg[0];
                  state_reg   <= DATA;
               end else begin
                  div_reg <= div_reg + 1'b1;
               end
            end
            DATA: begin
               if (div_last) begin
                  div_reg   <= '0;
                  par_reg   <= par_reg ^ shift_reg[0];
                  shift_reg <= shift_reg >> 1;
                  if (bit_cnt_reg == 4'(DATA_BITS - 1)) begin
                     bit_cnt_reg <= '0;
                     if (PARITY != 0) begin
                        tx_line_reg <= par_reg ^ shift_reg[0] ^ (PARITY == int'(PAR_ODD));
                        state_reg   <= uart_pkg::PARITY;
                     end else begin
                        tx_line_reg <= 1'b1;
                        state_reg   <= STOP;
                     end
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     tx_line_reg <= shift_reg[1];
                  end
               end else begin
                  div_reg <= div_reg + 1'b1;
               end
            end
            uart_pkg::PARITY: begin
               if (div_last) begin
                  div_reg     <= '0;
                  tx_line_reg <= 1'b1;
                  state_reg   <= STOP;
               end else begin
                  div_reg <= div_reg + 1'b1;
               end
            end
            STOP: begin
               if (div_last) begin
                  div_reg <= '0;
                  if (bit_cnt_reg == 4'(STOP_BITS - 1)) begin
                     bit_cnt_reg <= '0;
                     if (pop) begin
                        shift_reg   <= fifo_rd_data;
                        par_reg     <= 1'b0;
                        tx_line_reg <= 1'b0;
                        state_reg   <= START;
                     end else begin
                        tx_line_reg <= 1'b1;
                        state_reg   <= IDLE;
                     end
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  end
               end else begin
                  div_reg <= div_reg + 1'b1;
               end
            end
            default: begin
               state_reg   <= IDLE;
               tx_line_reg <= 1'b1;
            end
         endcase
      end
   end

   assign bus.tx_ready = ~fifo_full;
   assign tx_line      = tx_line_reg;
   assign busy         = busy_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: four transmitter configurations share clock and reset.
// inst 0: 8N1, inst 1: 8E1, inst 2: 8O1, inst 3: 7N2; all DIV_RATIO=4, FIFO_DEPTH=4.
module tb_uart_tx_fifo;

   logic       clk;
   logic       rst;
   logic [8:0] tb_data;
   logic [3:0] valid;
   logic [3:0] line_w;
   logic [3:0] busy_w;
   logic [3:0] ready_w;
   logic [2:0] level_w [4];

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         inst;
      logic [8:0] data;
      int         nbits;
      logic [15:0] frame;   // bit i = i-th bit on the line, start bit first
   } vec_t;

   vec_t vecs [8];

   // Stream scenario on inst 0 (8N1): push schedule and expected frame order.
   int         st_n_push;
   int         st_push_edge [8];
   logic [7:0] st_push_data [8];
   int         st_n_frames;
   logic [7:0] st_frame [8];
   logic [2:0] lvl_hist [256];
   logic       ready_hist [256];

   uart_tx_fifo_if #(.DATA_BITS(8)) bus0 ();
   uart_tx_fifo_if #(.DATA_BITS(8)) bus1 ();
   uart_tx_fifo_if #(.DATA_BITS(8)) bus2 ();
   uart_tx_fifo_if #(.DATA_BITS(7)) bus3 ();

   assign bus0.tx_data  = tb_data[7:0];
   assign bus1.tx_data  = tb_data[7:0];
   assign bus2.tx_data  = tb_data[7:0];
   assign bus3.tx_data  = tb_data[6:0];
   assign bus0.tx_valid = valid[0];
   assign bus1.tx_valid = valid[1];
   assign bus2.tx_valid = valid[2];
   assign bus3.tx_valid = valid[3];
   assign ready_w[0]    = bus0.tx_ready;
   assign ready_w[1]    = bus1.tx_ready;
   assign ready_w[2]    = bus2.tx_ready;
   assign ready_w[3]    = bus3.tx_ready;

   uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_RATIO(4), .FIFO_DEPTH(4)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .tx_line(line_w[0]), .busy(busy_w[0]), .fifo_level(level_w[0]));
   uart_tx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DIV_RATIO(4), .FIFO_DEPTH(4)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .tx_line(line_w[1]), .busy(busy_w[1]), .fifo_level(level_w[1]));
   uart_tx_fifo #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DIV_RATIO(4), .FIFO_DEPTH(4)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2), .tx_line(line_w[2]), .busy(busy_w[2]), .fifo_level(level_w[2]));
   uart_tx_fifo #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .DIV_RATIO(4), .FIFO_DEPTH(4)) dut3 (
      .clk(clk), .rst(rst), .bus(bus3), .tx_line(line_w[3]), .busy(busy_w[3]), .fifo_level(level_w[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, exp);
      end
   endtask

   task automatic wait_idle(input int inst);
      int c = 0;
      while (busy_w[2'(inst)] && c < 2000) begin
         @(negedge clk);
         c++;
      end
      if (busy_w[2'(inst)]) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout inst %0d: busy 1, required 0", inst);
      end
   endtask

   // Expected line level for bit k of an 8N1 frame.
   function automatic logic exp_bit_8n1(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return b[3'(k - 1)];
   endfunction

   // One table vector: push a word, then compare every cycle of the frame.
   task automatic run_vec(input int idx, input vec_t v);
      int   last;
      int   bad_line;
      int   bad_busy;
      int   first_bad;
      logic exp_l;
      logic exp_b;
      wait_idle(v.inst);
      last      = 4 * v.nbits;
      bad_line  = 0;
      bad_busy  = 0;
      first_bad = -1;
      tb_data   = v.data;
      valid[2'(v.inst)] = 1'b1;
      for (int j = 0; j <= last + 1; j++) begin
         @(posedge clk);
         @(negedge clk);
         valid = '0;
         exp_l = (j == 0 || j > last) ? 1'b1 : v.frame[4'((j - 1) / 4)];
         exp_b = (j <= last);
         if (line_w[2'(v.inst)] !== exp_l) begin
            if (first_bad < 0) first_bad = j;
            bad_line++;
         end
         if (busy_w[2'(v.inst)] !== exp_b) bad_busy++;
      end
      $display("vec %0d inst %0d data 0x%h: line errors %0d (first cycle %0d), busy errors %0d",
               idx, v.inst, v.data, bad_line, first_bad, bad_busy);
      check($sformatf("vec%0d_line", idx), bad_line, 0);
      check($sformatf("vec%0d_busy", idx), bad_busy, 0);
   endtask

   // Multi-frame run on inst 0 with an arbitrary push schedule.
   task automatic stream_run(input string name);
      int   last;
      int   bad_line;
      int   bad_busy;
      int   first_bad;
      logic exp_l;
      logic exp_b;
      last      = st_n_frames * 40;
      bad_line  = 0;
      bad_busy  = 0;
      first_bad = -1;
      for (int j = 0; j <= last + 1; j++) begin
         valid[0] = 1'b0;
         for (int p = 0; p < st_n_push; p++) begin
            if (st_push_edge[p] == j) begin
               valid[0] = 1'b1;
               tb_data  = {1'b0, st_push_data[p]};
            end
         end
         @(posedge clk);
         @(negedge clk);
         if (j == 0 || j > last) exp_l = 1'b1;
         else exp_l = exp_bit_8n1(st_frame[3'((j - 1) / 40)], ((j - 1) % 40) / 4);
         exp_b = (j <= last);
         lvl_hist[8'(j)]   = level_w[0];
         ready_hist[8'(j)] = ready_w[0];
         if (line_w[0] !== exp_l) begin
            if (first_bad < 0) first_bad = j;
            bad_line++;
         end
         if (busy_w[0] !== exp_b) bad_busy++;
      end
      valid[0] = 1'b0;
      $display("stream %s: %0d frames, line errors %0d (first cycle %0d), busy errors %0d",
               name, st_n_frames, bad_line, first_bad, bad_busy);
      check({name, "_line"}, bad_line, 0);
      check({name, "_busy"}, bad_busy, 0);
   endtask

   initial begin
      vecs[0] = '{inst: 0, data: 9'h055, nbits: 10, frame: 16'b1010101010};
      vecs[1] = '{inst: 0, data: 9'h0FF, nbits: 10, frame: 16'b1111111110};
      vecs[2] = '{inst: 1, data: 9'h007, nbits: 11, frame: 16'b11000001110};
      vecs[3] = '{inst: 1, data: 9'h0A5, nbits: 11, frame: 16'b10101001010};
      vecs[4] = '{inst: 2, data: 9'h007, nbits: 11, frame: 16'b10000001110};
      vecs[5] = '{inst: 2, data: 9'h000, nbits: 11, frame: 16'b11000000000};
      vecs[6] = '{inst: 3, data: 9'h041, nbits: 10, frame: 16'b1110000010};
      vecs[7] = '{inst: 3, data: 9'h013, nbits: 10, frame: 16'b1100100110};

      rst     = 1'b0;
      valid   = '0;
      tb_data = '0;

      // Reset state, with a clock edge inside reset.
      #12;
      check("rst_line", int'(line_w), 15);
      check("rst_busy", int'(busy_w), 0);
      check("rst_ready", int'(ready_w), 0);
      check("rst_level", int'(level_w[0]), 0);
      $display("reset: line %b busy %b ready %b", line_w, busy_w, ready_w);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("ready_after_release", int'(ready_w), 15);

      // Single frames across the four frame formats.
      for (int i = 0; i < 8; i++) begin
         run_vec(i, vecs[i]);
      end

      // Burst of six writes into a four-deep FIFO; the sixth is refused.
      wait_idle(0);
      st_n_push = 6;
      for (int p = 0; p < 6; p++) begin
         st_push_edge[p] = p;
         st_push_data[p] = 8'h10 + 8'(p);
      end
      st_n_frames = 5;
      for (int f = 0; f < 5; f++) st_frame[f] = 8'h10 + 8'(f);
      stream_run("burst");
      check("burst_level_full", int'(lvl_hist[5]), 4);
      check("burst_ready_full", int'(ready_hist[5]), 0);
      check("burst_level_after_pop", int'(lvl_hist[41]), 3);
      check("burst_ready_after_pop", int'(ready_hist[41]), 1);

      // Push and pop on the same edge, both from idle and at a frame boundary.
      wait_idle(0);
      st_n_push       = 3;
      st_push_edge[0] = 0;  st_push_data[0] = 8'h3C;
      st_push_edge[1] = 1;  st_push_data[1] = 8'h5A;
      st_push_edge[2] = 41; st_push_data[2] = 8'hC3;
      st_n_frames = 3;
      st_frame[0] = 8'h3C;
      st_frame[1] = 8'h5A;
      st_frame[2] = 8'hC3;
      stream_run("pushpop");
      check("pushpop_level_idle", int'(lvl_hist[1]), 1);
      check("pushpop_level_stop", int'(lvl_hist[41]), 1);

      // Reset in the middle of the data bits with a word still queued.
      wait_idle(0);
      tb_data  = 9'h055;
      valid[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tb_data = 9'h033;
      @(posedge clk);
      @(negedge clk);
      valid[0] = 1'b0;
      repeat (16) @(posedge clk);
      #1;
      check("midframe_line_data", int'(line_w[0]), 0);
      check("midframe_level", int'(level_w[0]), 1);
      #1;
      rst = 1'b0;
      #1;
      check("abort_line", int'(line_w[0]), 1);
      check("abort_busy", int'(busy_w[0]), 0);
      check("abort_level", int'(level_w[0]), 0);
      check("abort_ready", int'(ready_w[0]), 0);
      $display("abort: line %b busy %b level %0d", line_w[0], busy_w[0], level_w[0]);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_ready_release", int'(ready_w[0]), 1);
      st_n_push       = 1;
      st_push_edge[0] = 0;
      st_push_data[0] = 8'hA5;
      st_n_frames     = 1;
      st_frame[0]     = 8'hA5;
      stream_run("after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
